// File: rtl/layer_1_ctrl.sv
// -----------------------------------------------------------------------------
// layer_1_ctrl
// Read-side sequencer for the layer-1 pooled-feature buffer. Walks the 3x3
// window read pointer of layer_1 across one frame, presents each window to the
// layer-2 datapath and pulses tx_done at end of frame (or on abort) so the
// layer_1 write/read pointers rewind.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   frame_strt   in   arms a new frame (only honoured in IDLE)
//   abort        in   terminates the current frame (ignored in IDLE/DONE)
//   rd           in   layer_1 has fully written the current window
//   l2_rdy       in   layer-2 accepts the presented window
//   addr_rd_inc  out  one-cycle pulse advancing the layer_1 window pointer
//   l2_vld       out  layer_1.dout holds a valid window for layer-2
//   win_col      out  column of the presented window, 0..WIN_PER_ROW-1
//   win_row      out  row of the presented window, 0..NUM_ROWS-1
//   tx_done      out  one-cycle pulse rewinding the layer_1 pointers
//   busy         out  high in every state except IDLE
//   fsm_state    out  current FSM state encoding, for observation only
//
// Handshake: l2_vld rises when a window is presented and then holds, with
// win_col/win_row stable, until a clock edge where l2_vld & l2_rdy are both
// high; that edge transfers the window. l2_rdy may change freely while
// l2_vld is low, and l2_vld never drops without a transfer except on abort
// or reset.
// -----------------------------------------------------------------------------
module layer_1_ctrl #(
   parameter int WIN_PER_ROW = 11,
   parameter int NUM_ROWS    = 11,
   parameter int RAM_LAT     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_strt,
   input  logic       abort,
   input  logic       rd,
   input  logic       l2_rdy,
   output logic       addr_rd_inc,
   output logic       l2_vld,
   output logic [3:0] win_col,
   output logic [3:0] win_row,
   output logic       tx_done,
   output logic       busy,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_PRESENT = 3'd2,
      S_ADVANCE = 3'd3,
      S_SETTLE  = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [3:0] COL_LAST    = 4'(WIN_PER_ROW - 1);
   localparam logic [3:0] ROW_LAST    = 4'(NUM_ROWS - 1);
   localparam logic [1:0] SETTLE_LAST = 2'(RAM_LAT - 1);

   state_t     state;
   logic [1:0] settle_cnt;
   logic       last_win;
   logic       abort_ok;

   assign last_win  = (win_col == COL_LAST) && (win_row == ROW_LAST);
   // Abort only acts while a frame is in flight; DONE is already ending it.
   assign abort_ok  = abort && (state != S_IDLE) && (state != S_DONE);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         settle_cnt  <= 2'd0;
         addr_rd_inc <= 1'b0;
         l2_vld      <= 1'b0;
         win_col     <= 4'd0;
         win_row     <= 4'd0;
         tx_done     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         // Single-cycle pulses default low; only one branch raises either.
         addr_rd_inc <= 1'b0;
         tx_done     <= 1'b0;

         if (abort_ok) begin
            // Abort wins over both the handshake and rd.
            state   <= S_DONE;
            l2_vld  <= 1'b0;
            tx_done <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (frame_strt) begin
                     win_col <= 4'd0;
                     win_row <= 4'd0;
                     busy    <= 1'b1;
                     state   <= S_WAIT;
                  end
               end

               S_WAIT: begin
                  if (rd) begin
                     l2_vld <= 1'b1;
                     state  <= S_PRESENT;
                  end
               end

               S_PRESENT: begin
                  if (l2_rdy) begin
                     l2_vld <= 1'b0;
                     if (last_win) begin
                        // Last window: the pointer is rewound by tx_done
                        // rather than advanced.
                        tx_done <= 1'b1;
                        state   <= S_DONE;
                     end else begin
                        addr_rd_inc <= 1'b1;
                        state       <= S_ADVANCE;
                     end
                  end
               end

               S_ADVANCE: begin
                  if (win_col == COL_LAST) begin
                     win_col <= 4'd0;
                     win_row <= win_row + 4'd1;
                  end else begin
                     win_col <= win_col + 4'd1;
                  end
                  settle_cnt <= 2'd0;
                  state      <= S_SETTLE;
               end

               S_SETTLE: begin
                  // Covers the layer_1 RAM read latency after the advance.
                  if (settle_cnt == SETTLE_LAST) begin
                     state <= S_WAIT;
                  end else begin
                     settle_cnt <= settle_cnt + 2'd1;
                  end
               end

               S_DONE: begin
                  win_col <= 4'd0;
                  win_row <= 4'd0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end

               default: begin
                  busy   <= 1'b0;
                  l2_vld <= 1'b0;
                  state  <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_layer_1_ctrl.sv
// -----------------------------------------------------------------------------
// tb_layer_1_ctrl
// Directed bench for layer_1_ctrl. Instance dut uses the default RAM_LAT of 1;
// instance dut_b uses RAM_LAT = 3. Window coordinates expected for each
// handshake are queued when a frame is started and popped on each transfer.
// -----------------------------------------------------------------------------
module tb_layer_1_ctrl;

   localparam int WPR   = 11;
   localparam int NR    = 11;
   localparam int NWIN  = WPR * NR;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- instance A (RAM_LAT = 1) ----------------
   logic       frame_strt, abort, rd, l2_rdy;
   logic       addr_rd_inc, l2_vld, tx_done, busy;
   logic [3:0] win_col, win_row;
   logic [2:0] fsm_state;

   layer_1_ctrl #(.WIN_PER_ROW(WPR), .NUM_ROWS(NR), .RAM_LAT(LAT_A)) dut (
      .clk(clk), .rst(rst), .frame_strt(frame_strt), .abort(abort),
      .rd(rd), .l2_rdy(l2_rdy), .addr_rd_inc(addr_rd_inc), .l2_vld(l2_vld),
      .win_col(win_col), .win_row(win_row), .tx_done(tx_done), .busy(busy),
      .fsm_state(fsm_state)
   );

   // ---------------- instance B (RAM_LAT = 3) ----------------
   logic       b_frame_strt, b_abort, b_rd, b_rdy;
   logic       b_inc, b_vld, b_tx, b_busy;
   logic [3:0] b_col, b_row;
   logic [2:0] b_state;

   layer_1_ctrl #(.WIN_PER_ROW(WPR), .NUM_ROWS(NR), .RAM_LAT(LAT_B)) dut_b (
      .clk(clk), .rst(rst), .frame_strt(b_frame_strt), .abort(b_abort),
      .rd(b_rd), .l2_rdy(b_rdy), .addr_rd_inc(b_inc), .l2_vld(b_vld),
      .win_col(b_col), .win_row(b_row), .tx_done(b_tx), .busy(b_busy),
      .fsm_state(b_state)
   );

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int hs_cnt, inc_cnt, tx_cnt, first_vld_cyc, tx_cyc;
   logic [3:0] last_col, last_row;
   int b_hs = 0, b_inc_cnt = 0, b_tx_cnt = 0, b_starts = 0, b_run = 0;
   logic vld_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_frame();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < WPR; c++)
            exp_q.push_back({4'(r), 4'(c)});
   endtask

   // Advance one cycle: remember what the DUTs presented before the edge,
   // then observe the result at the following falling edge.
   task automatic step();
      logic       p_vld, p_rdy, p_abort, p_rst, pb_vld, pb_rdy, pb_inc, pb_busy;
      logic [3:0] p_col, p_row;
      logic [7:0] exp_w;
      p_vld = l2_vld;  p_rdy = l2_rdy;  p_abort = abort;  p_rst = rst;
      p_col = win_col; p_row = win_row;
      pb_vld = b_vld;  pb_rdy = b_rdy;  pb_inc = b_inc;   pb_busy = b_busy;
      @(negedge clk);
      cyc++;
      // Instance A: a transfer happens only when not overridden by abort/rst.
      if (p_vld === 1'b1 && p_rdy && !p_abort && !p_rst) begin
         hs_cnt++;
         last_col = p_col;
         last_row = p_row;
         check("sb_nonempty", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("sb_window", 32'({p_row, p_col}), 32'(exp_w));
         end
      end
      if (addr_rd_inc === 1'b1) inc_cnt++;
      if (tx_done === 1'b1) begin
         tx_cnt++;
         tx_cyc = cyc;
      end
      if (l2_vld === 1'b1 && p_vld !== 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (addr_rd_inc === 1'b1 || tx_done === 1'b1)
         check("pulse_excl", 32'(addr_rd_inc & tx_done), 0);
      // Instance B bookkeeping.
      if (pb_vld === 1'b1 && pb_rdy && !p_rst) b_hs++;
      if (b_inc === 1'b1) b_inc_cnt++;
      if (b_tx === 1'b1) b_tx_cnt++;
      if (b_busy === 1'b1 && pb_busy === 1'b0) b_starts++;
      if (pb_inc === 1'b1) check("b_settle_entry", 32'(b_state), 4);
      if (b_state === 3'd4) b_run++;
      else if (b_run != 0) begin
         check("b_settle_len", 32'(b_run), LAT_B);
         b_run = 0;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      frame_strt = 1'b0; abort = 1'b0; rd = 1'b0; l2_rdy = 1'b0;
      b_frame_strt = 1'b0; b_abort = 1'b0; b_rd = 1'b0; b_rdy = 1'b0;
      hs_cnt = 0; inc_cnt = 0; tx_cnt = 0; first_vld_cyc = -1; tx_cyc = 0;
      last_col = 4'd0; last_row = 4'd0; vld_seen = 1'b0;

      // Reset with random inputs; frame_strt forced high on the second cycle.
      for (int i = 0; i < 2; i++) begin
         frame_strt = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         abort  = 1'($urandom_range(0, 1));
         rd     = 1'($urandom_range(0, 1));
         l2_rdy = 1'($urandom_range(0, 1));
         step();
         check("rst_outputs", 32'({addr_rd_inc, l2_vld, tx_done, busy, win_col, win_row}), 0);
         check("rst_state", 32'(fsm_state), 0);
      end
      rst = 1'b0; frame_strt = 1'b0; abort = 1'b0; rd = 1'b0; l2_rdy = 1'b0;
      step();
      check("rst_frame_strt_ignored", 32'(busy), 0);

      // Abort in IDLE does nothing.
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("idle_abort_tx", 32'(tx_done), 0);
      check("idle_abort_busy", 32'(busy), 0);

      // Full frame with rd and l2_rdy held high.
      push_frame();
      hs_cnt = 0; inc_cnt = 0; tx_cnt = 0; first_vld_cyc = -1;
      rd = 1'b1; l2_rdy = 1'b1; frame_strt = 1'b1;
      step();
      frame_strt = 1'b0;
      check("start_busy", 32'(busy), 1);
      check("start_state_wait", 32'(fsm_state), 1);
      check("start_coords", 32'({win_row, win_col}), 0);
      for (int i = 0; i < 2000 && tx_cnt == 0; i++) step();
      check("frame_tx_cnt", 32'(tx_cnt), 1);
      check("frame_handshakes", 32'(hs_cnt), NWIN);
      check("frame_addr_inc", 32'(inc_cnt), NWIN - 1);
      check("frame_length", 32'(tx_cyc - first_vld_cyc), (NWIN - 1) * (3 + LAT_A) + 1);
      check("frame_last_col", 32'(last_col), WPR - 1);
      check("frame_last_row", 32'(last_row), NR - 1);
      check("frame_sb_empty", 32'(exp_q.size()), 0);
      step();
      check("frame_end_busy", 32'(busy), 0);
      check("frame_end_idle", 32'(fsm_state), 0);

      // Second frame: backpressure on window 3.
      push_frame();
      hs_cnt = 0; inc_cnt = 0; tx_cnt = 0;
      frame_strt = 1'b1;
      step();
      frame_strt = 1'b0;
      for (int i = 0; i < 200 && !(l2_vld === 1'b1 && win_col == 4'd3); i++) step();
      check("bp_reach_win3", 32'(l2_vld === 1'b1 && win_col == 4'd3), 1);
      l2_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_vld_hold", 32'(l2_vld), 1);
         check("bp_col_stable", 32'(win_col), 3);
         check("bp_no_inc", 32'(addr_rd_inc), 0);
      end
      l2_rdy = 1'b1;
      step();
      check("bp_resume_inc", 32'(addr_rd_inc), 1);
      check("bp_resume_vld", 32'(l2_vld), 0);
      check("bp_col_t1", 32'(win_col), 3);
      step();
      check("bp_col_t2", 32'(win_col), 4);

      // Data starvation after window 12.
      for (int i = 0; i < 200 && hs_cnt < 13; i++) step();
      check("st_reach_win12", 32'(hs_cnt), 13);
      rd = 1'b0;
      vld_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         vld_seen = vld_seen | l2_vld;
      end
      check("st_no_vld", 32'(vld_seen), 0);
      check("st_no_extra_inc", 32'(inc_cnt), 13);
      check("st_hold_wait", 32'(fsm_state), 1);
      rd = 1'b1;
      step();
      check("st_vld_return", 32'(l2_vld), 1);
      check("st_coords", 32'({win_row, win_col}), 32'({4'd1, 4'd2}));

      // Abort during window 50 with l2_rdy high in the same cycle.
      for (int i = 0; i < 400 && !(l2_vld === 1'b1 && hs_cnt == 50); i++) step();
      check("ab_reach_win50", 32'(l2_vld === 1'b1 && hs_cnt == 50), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab_tx_done", 32'(tx_done), 1);
      check("ab_vld_low", 32'(l2_vld), 0);
      check("ab_no_inc", 32'(addr_rd_inc), 0);
      check("ab_no_handshake", 32'(hs_cnt), 50);
      step();
      check("ab_idle", 32'(fsm_state), 0);
      check("ab_busy", 32'(busy), 0);
      check("ab_coords_clear", 32'({win_row, win_col}), 0);
      check("ab_tx_cnt", 32'(tx_cnt), 1);

      // Restart after abort, then reset mid-frame.
      exp_q.delete();
      push_frame();
      hs_cnt = 0; tx_cnt = 0;
      frame_strt = 1'b1;
      step();
      frame_strt = 1'b0;
      check("rs_busy", 32'(busy), 1);
      check("rs_coords", 32'({win_row, win_col}), 0);
      for (int i = 0; i < 50 && hs_cnt < 2; i++) step();
      check("rs_two_windows", 32'(hs_cnt), 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_no_tx", 32'(tx_done), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_idle", 32'(fsm_state), 0);
      exp_q.delete();
      rd = 1'b0; l2_rdy = 1'b0;

      // Instance B: RAM_LAT = 3 with frame_strt high every cycle of the frame.
      b_rd = 1'b1; b_rdy = 1'b1; b_frame_strt = 1'b1;
      for (int i = 0; i < 3000 && b_tx_cnt == 0; i++) step();
      b_frame_strt = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("b_one_frame", 32'(b_starts), 1);
      check("b_tx_cnt", 32'(b_tx_cnt), 1);
      check("b_handshakes", 32'(b_hs), NWIN);
      check("b_addr_inc", 32'(b_inc_cnt), NWIN - 1);
      check("b_idle_after", 32'(b_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
